stack_unit: RTL

- Hardware LIFO that serves the Push/Pop/Tos strobes issued by the multicycle stack-machine controller/datapath.
- Holds operand words in a register-file stack, presents a registered read word back to the datapath, and flags overflow/underflow.
- Sits beside the datapath. The datapath drives the strobes and write data; this block returns data and status.

---
 rtl/stack_pkg.sv | 39 +++
 rtl/stack_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stack_pkg.sv
// Shared stack definitions: default word/depth constants and the
// stack operation enum decoded from the push/pop/tos strobes.
package stack_pkg;

    localparam int STACK_DATA_W = 8;
    localparam int STACK_DEPTH  = 16;

    typedef enum logic [2:0] {
        NOP,
        PUSH,
        POP,
        TOS,
        REPL
    } stack_op_e;

    // Strobe priority: pop+push (with or without tos) replaces the
    // top; pop dominates tos; tos+push reads first and then pushes,
    // so the caller still needs the raw push strobe for TOS.
    function automatic stack_op_e decode_op(
        input logic push_s,
        input logic pop_s,
        input logic tos_s
    );
        stack_op_e op;
        if (push_s && pop_s) begin
            op = REPL;
        end else if (pop_s) begin
            op = POP;
        end else if (tos_s) begin
            op = TOS;
        end else if (push_s) begin
            op = PUSH;
        end else begin
            op = NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_unit.sv
// Register-file LIFO serving push/pop/tos strobes from the datapath.
// Ports: clk, rst (sync, active-high); push/pop/tos strobes, din;
//   dout/dout_valid registered read; count/empty/full occupancy;
//   ovf_err/unf_err sticky errors; hwm (only with STACK_HIGHWATER_EN).
module stack_unit
    import stack_pkg::*;
#(
    parameter  int DATA_W = STACK_DATA_W,
    parameter  int DEPTH  = STACK_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [PTR_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf_err,
    output logic              unf_err
`ifdef STACK_HIGHWATER_EN
    ,
    output logic [PTR_W-1:0]  hwm
`endif
);

    localparam int AW = PTR_W - 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              we;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     top_idx;
    logic [DATA_W-1:0] top;
    logic              is_empty;
    logic              is_full;
    stack_op_e         op;

    assign op       = decode_op(push, pop, tos);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == PTR_W'(DEPTH));
    // At count==DEPTH the low bits wrap to 0, so minus one still
    // lands on the last entry.
    assign top_idx  = count_q[AW-1:0] - AW'(1);
    assign top      = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = count_q[AW-1:0];
        unique case (op)
            NOP: begin
            end
            PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    count_d = count_q + PTR_W'(1);
                end
            end
            POP: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    dout_d  = top;
                    dv_d    = 1'b1;
                    count_d = count_q - PTR_W'(1);
                end
            end
            TOS: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    dout_d = top;
                    dv_d   = 1'b1;
                end
                if (push) begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + PTR_W'(1);
                    end
                end
            end
            REPL: begin
                // Empty stack has no top to replace: degrade to push.
                if (is_empty) begin
                    unf_d   = 1'b1;
                    we      = 1'b1;
                    count_d = count_q + PTR_W'(1);
                end else begin
                    dout_d = top;
                    dv_d   = 1'b1;
                    we     = 1'b1;
                    waddr  = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef STACK_HIGHWATER_EN
    logic [PTR_W-1:0] hwm_q;

    // Tracks the registered count, so it lags count by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= '0;
        end else if (count_q > hwm_q) begin
            hwm_q <= count_q;
        end
    end

    assign hwm = hwm_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign count      = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign ovf_err    = ovf_q;
    assign unf_err    = unf_q;

endmodule
